axi_lite_config_slave: RTL and testbench

AXI-Lite responder holding the dot-product accelerator's configuration, result and status registers. It is the far end of the accelerator master's config bus: it serves the master's register reads (0x00–0x10) and its result/status writes (0x10, 0x14). A simple host-side register port loads the configuration and collects the result. The block raises `start_signal` and `irq` towards the system.

---
 rtl/dp_axi_pkg.sv | 49 ++++
 rtl/axi_lite_config_slave.sv | 202 ++++++++++++++++++++
 tb/tb_axi_lite_config_slave.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_axi_pkg.sv
// Shared definitions for the dot-product accelerator config bus: register map,
// AXI response codes, FSM state types and the AXI address decoder.
package dp_axi_pkg;

  localparam logic [4:0] OFF_CONTROL = 5'h00;
  localparam logic [4:0] OFF_VEC_A   = 5'h04;
  localparam logic [4:0] OFF_VEC_B   = 5'h08;
  localparam logic [4:0] OFF_VEC_LEN = 5'h0C;
  localparam logic [4:0] OFF_OUTPUT  = 5'h10;
  localparam logic [4:0] OFF_STATUS  = 5'h14;
  localparam logic [4:0] OFF_RESULT  = 5'h18;

  localparam logic [2:0] IDX_CONTROL = 3'd0;
  localparam logic [2:0] IDX_VEC_A   = 3'd1;
  localparam logic [2:0] IDX_VEC_B   = 3'd2;
  localparam logic [2:0] IDX_VEC_LEN = 3'd3;
  localparam logic [2:0] IDX_OUTPUT  = 3'd4;
  localparam logic [2:0] IDX_STATUS  = 3'd5;
  localparam logic [2:0] IDX_RESULT  = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic [2:0] {
    M_IDLE, M_FETCH_A, M_FETCH_B, M_ACCUM, M_WRITE_RESULT, M_WRITE_STATUS
  } master_state_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       rd_ok;
    logic       wr_ok;
  } decode_t;

  // AXI view of the map: reads reach 0x00-0x14, writes only 0x10 (RESULT) and 0x14.
  function automatic decode_t axi_decode(input logic [4:0] off);
    decode_t d;
    d.idx   = off[4:2];
    d.rd_ok = 1'b0;
    d.wr_ok = 1'b0;
    if (off[1:0] == 2'b00) begin
      d.rd_ok = (off <= OFF_STATUS);
      d.wr_ok = (off == OFF_OUTPUT) || (off == OFF_STATUS);
    end
    return d;
  endfunction

endpackage

// File: rtl/axi_lite_config_slave.sv
// AXI-Lite responder for the accelerator master plus a single-cycle host register port.
// Handshakes: a beat transfers on the rising ACLK edge where VALID and READY are both high.
module axi_lite_config_slave
  import dp_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic                  HOST_WE,
  input  logic [4:0]            HOST_ADDR,
  input  logic [31:0]           HOST_WDATA,
  output logic [31:0]           HOST_RDATA,
  output logic                  start_signal,
  output logic                  irq,
  output rd_state_t             dbg_rd_state,
  output wr_state_t             dbg_wr_state
);

  logic live;
  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic [DATA_WIDTH-1:0] ctrl_q, vec_a_q, vec_b_q, vec_len_q, out_addr_q, result_q;
  logic                  done_q, start_q;
  logic [DATA_WIDTH-1:0] rdata_q, w_data_q, axi_rd_word, wr_data;
  logic [1:0]            rresp_q, bresp_q;
  logic [4:0]            aw_addr_q, wr_off;
  logic                  ar_fire, aw_fire, w_fire, wr_do;
  logic                  result_we, done_set, host_ok, host_ctrl_we, host_clr;
  decode_t               ar_dec, wr_dec;
  logic                  unused_bits;

  assign unused_bits = ^{ARADDR[ADDR_WIDTH-1:5], AWADDR[ADDR_WIDTH-1:5],
                         ar_dec.wr_ok, wr_dec.rd_ok};

  // Readies stay low until the first clock after reset release.
  assign ARREADY = live && (rd_state == R_IDLE);
  assign AWREADY = live && (wr_state == W_IDLE || wr_state == W_HAVE_W);
  assign WREADY  = live && (wr_state == W_IDLE || wr_state == W_HAVE_AW);
  assign RVALID  = (rd_state == R_DATA);
  assign BVALID  = (wr_state == W_RESP);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign BRESP   = bresp_q;
  assign start_signal = start_q;
  assign irq          = done_q;
  assign dbg_rd_state = rd_state;
  assign dbg_wr_state = wr_state;

  assign ar_fire = ARVALID && ARREADY;
  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_dec  = axi_decode(ARADDR[4:0]);

  always_comb begin
    axi_rd_word = '0;
    case (ar_dec.idx)
      IDX_CONTROL: axi_rd_word = ctrl_q;
      IDX_VEC_A:   axi_rd_word = vec_a_q;
      IDX_VEC_B:   axi_rd_word = vec_b_q;
      IDX_VEC_LEN: axi_rd_word = vec_len_q;
      IDX_OUTPUT:  axi_rd_word = out_addr_q;
      IDX_STATUS:  axi_rd_word = {{(DATA_WIDTH-1){1'b0}}, done_q};
      default:     axi_rd_word = '0;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_fire) rd_next = R_DATA;
      R_DATA:  if (RREADY)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // The write is performed on the edge of whichever of AW/W arrives last.
  always_comb begin
    wr_next = wr_state;
    wr_do   = 1'b0;
    wr_off  = aw_addr_q;
    wr_data = w_data_q;
    case (wr_state)
      W_IDLE: begin
        if (aw_fire && w_fire) begin
          wr_do   = 1'b1;
          wr_off  = AWADDR[4:0];
          wr_data = WDATA;
          wr_next = W_RESP;
        end else if (aw_fire) begin
          wr_next = W_HAVE_AW;
        end else if (w_fire) begin
          wr_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_fire) begin
        wr_do   = 1'b1;
        wr_data = WDATA;
        wr_next = W_RESP;
      end
      W_HAVE_W: if (aw_fire) begin
        wr_do   = 1'b1;
        wr_off  = AWADDR[4:0];
        wr_next = W_RESP;
      end
      W_RESP:  if (BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  assign wr_dec    = axi_decode(wr_off);
  assign result_we = wr_do && wr_dec.wr_ok && (wr_dec.idx == IDX_OUTPUT);
  assign done_set  = wr_do && wr_dec.wr_ok && (wr_dec.idx == IDX_STATUS) && wr_data[0];

  assign host_ok      = HOST_WE && (HOST_ADDR[1:0] == 2'b00);
  assign host_ctrl_we = host_ok && (HOST_ADDR[4:2] == IDX_CONTROL);
  assign host_clr     = host_ok && (HOST_ADDR[4:2] == IDX_STATUS) && HOST_WDATA[0];

  always_comb begin
    HOST_RDATA = '0;
    if (HOST_ADDR[1:0] == 2'b00) begin
      case (HOST_ADDR[4:2])
        IDX_CONTROL: HOST_RDATA = ctrl_q;
        IDX_VEC_A:   HOST_RDATA = vec_a_q;
        IDX_VEC_B:   HOST_RDATA = vec_b_q;
        IDX_VEC_LEN: HOST_RDATA = vec_len_q;
        IDX_OUTPUT:  HOST_RDATA = out_addr_q;
        IDX_STATUS:  HOST_RDATA = {31'b0, done_q};
        IDX_RESULT:  HOST_RDATA = result_q;
        default:     HOST_RDATA = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      live      <= 1'b0;
      rd_state  <= R_IDLE;
      wr_state  <= W_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
    end else begin
      live     <= 1'b1;
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (ar_fire) begin
        rdata_q <= ar_dec.rd_ok ? axi_rd_word : '0;
        rresp_q <= ar_dec.rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (aw_fire) aw_addr_q <= AWADDR[4:0];
      if (w_fire)  w_data_q  <= WDATA;
      if (wr_do)   bresp_q   <= wr_dec.wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q     <= '0;
      vec_a_q    <= '0;
      vec_b_q    <= '0;
      vec_len_q  <= '0;
      out_addr_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q <= host_ctrl_we && HOST_WDATA[0];
      if (host_ctrl_we) ctrl_q <= HOST_WDATA;
      if (done_set)     ctrl_q[0] <= 1'b0;
      if (host_ok && HOST_ADDR[4:2] == IDX_VEC_A)   vec_a_q    <= HOST_WDATA;
      if (host_ok && HOST_ADDR[4:2] == IDX_VEC_B)   vec_b_q    <= HOST_WDATA;
      if (host_ok && HOST_ADDR[4:2] == IDX_VEC_LEN) vec_len_q  <= HOST_WDATA;
      if (host_ok && HOST_ADDR[4:2] == IDX_OUTPUT)  out_addr_q <= HOST_WDATA;
      if (result_we) result_q <= wr_data;
      // A same-cycle AXI set beats the host W1C.
      if (done_set)      done_q <= 1'b1;
      else if (host_clr) done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_config_slave.sv
// Self-checking bench for axi_lite_config_slave: table-driven host/AXI register vectors
// plus hand-written sequences for stalls, write ordering, set/clear conflict and reset abort.
module tb_axi_lite_config_slave;
  import dp_axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] ARADDR = '0, AWADDR = '0, WDATA = '0;
  logic        ARVALID = 1'b0, AWVALID = 1'b0, WVALID = 1'b0;
  logic        RREADY = 1'b1, BREADY = 1'b1;
  logic        ARREADY, AWREADY, WREADY, RVALID, BVALID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP, BRESP;
  logic        HOST_WE = 1'b0;
  logic [4:0]  HOST_ADDR = '0;
  logic [31:0] HOST_WDATA = '0, HOST_RDATA;
  logic        start_signal, irq;
  rd_state_t   dbg_rd_state;
  wr_state_t   dbg_wr_state;

  axi_lite_config_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA),
    .HOST_RDATA(HOST_RDATA), .start_signal(start_signal), .irq(irq),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  // clock / watchdog
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];
  logic [1:0]  bexp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return ARREADY;
      1: return AWREADY;
      2: return WREADY;
      3: return AWREADY && WREADY;
      4: return RVALID;
      5: return BVALID;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int w, input string nm);
    int i = 0;
    while (!sig(w) && i < 20) begin
      @(negedge ACLK);
      i++;
    end
    if (!sig(w)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got 0, expected 1 within 20 cycles", nm);
    end
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge ACLK);
    HOST_WE = 1'b1; HOST_ADDR = a; HOST_WDATA = d;
    @(negedge ACLK);
    HOST_WE = 1'b0;
  endtask

  task automatic host_check(input logic [4:0] a, input logic [31:0] exp, input string nm);
    HOST_ADDR = a;
    #1;
    check(nm, 64'(HOST_RDATA), 64'(exp));
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                          input string nm);
    logic [33:0] e;
    exp_q.push_back({r, d});
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    wait_sig(0, {nm, "_ar"});
    @(negedge ACLK);
    ARVALID = 1'b0;
    check({nm, "_rvalid_lat"}, 64'(RVALID), 64'(1));
    wait_sig(4, {nm, "_r"});
    e = exp_q.pop_front();
    check({nm, "_rdata"}, 64'({RRESP, RDATA}), 64'(e));
    @(negedge ACLK);
  endtask

  task automatic do_aw(input logic [31:0] a);
    AWADDR = a; AWVALID = 1'b1;
    wait_sig(1, "aw");
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d);
    WDATA = d; WVALID = 1'b1;
    wait_sig(2, "w");
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic collect_b(input string nm);
    logic [1:0] e;
    check({nm, "_bvalid_lat"}, 64'(BVALID), 64'(1));
    wait_sig(5, {nm, "_b"});
    e = bexp_q.pop_front();
    check({nm, "_bresp"}, 64'(BRESP), 64'(e));
    @(negedge ACLK);
  endtask

  // mode 0: AW and W together, 1: AW first, 2: W first; gap = idle cycles between them
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int mode,
                           input int gap, input logic [1:0] r, input string nm);
    bexp_q.push_back(r);
    @(negedge ACLK);
    BREADY = 1'b1;
    case (mode)
      0: begin
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
        wait_sig(3, {nm, "_aww"});
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
      end
      1: begin
        do_aw(a);
        repeat (gap) @(negedge ACLK);
        do_w(d);
      end
      default: begin
        do_w(d);
        repeat (gap) @(negedge ACLK);
        do_aw(a);
      end
    endcase
    collect_b(nm);
  endtask

  function automatic logic [10:0] reset_bundle();
    return {ARREADY, AWREADY, WREADY, RVALID, BVALID, start_signal, irq, RRESP, BRESP};
  endfunction

  typedef struct {
    logic [4:0]  haddr;
    logic [31:0] hdata;
    logic [31:0] exp_host;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    string       nm;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{5'h04, 32'h100,  32'h100, 32'h04, 32'h100, RESP_OKAY,   "vec_a"};
    vecs[1] = '{5'h08, 32'h200,  32'h200, 32'h08, 32'h200, RESP_OKAY,   "vec_b"};
    vecs[2] = '{5'h0C, 32'h4,    32'h4,   32'h0C, 32'h4,   RESP_OKAY,   "vec_len"};
    vecs[3] = '{5'h10, 32'h300,  32'h300, 32'h10, 32'h300, RESP_OKAY,   "out_addr"};
    vecs[4] = '{5'h18, 32'hFFFF, 32'h0,   32'h18, 32'h0,   RESP_SLVERR, "result_ro"};

    // reset
    repeat (3) @(negedge ACLK);
    check("reset_outputs", 64'(reset_bundle()), 64'(0));
    check("reset_rdata", 64'(RDATA), 64'(0));
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("readies_after_reset", 64'({ARREADY, AWREADY, WREADY}), 64'(3'b111));
    host_check(5'h04, 32'h0, "reset_vec_a");

    // table-driven host write then AXI read
    foreach (vecs[i]) begin
      host_write(vecs[i].haddr, vecs[i].hdata);
      host_check(vecs[i].haddr, vecs[i].exp_host, {vecs[i].nm, "_host"});
      axi_read(vecs[i].raddr, vecs[i].exp_rd, vecs[i].exp_resp, vecs[i].nm);
    end

    // start pulse, also when bit0 is already set
    host_write(OFF_CONTROL, 32'h1);
    check("start_pulse_hi", 64'(start_signal), 64'(1));
    @(negedge ACLK);
    check("start_pulse_lo", 64'(start_signal), 64'(0));
    host_write(OFF_CONTROL, 32'h1);
    check("start_again_hi", 64'(start_signal), 64'(1));
    @(negedge ACLK);
    check("start_again_lo", 64'(start_signal), 64'(0));
    axi_read(32'h00, 32'h1, RESP_OKAY, "control");

    // RESULT write with AW first, W two cycles later
    axi_write(32'h10, 32'h2A, 1, 2, RESP_OKAY, "result_wr");
    host_check(OFF_RESULT, 32'h2A, "result_host");
    host_check(OFF_OUTPUT, 32'h300, "out_addr_kept");
    axi_read(32'h10, 32'h300, RESP_OKAY, "out_addr_axi");

    // done set clears CONTROL[0]; host W1C drops irq
    axi_write(32'h14, 32'h1, 0, 0, RESP_OKAY, "done_set");
    check("irq_set", 64'(irq), 64'(1));
    host_check(OFF_CONTROL, 32'h0, "control_cleared");
    axi_read(32'h00, 32'h0, RESP_OKAY, "control_axi");
    axi_read(32'h14, 32'h1, RESP_OKAY, "status_axi");
    host_write(OFF_STATUS, 32'h1);
    check("irq_w1c", 64'(irq), 64'(0));

    // same-cycle AXI set (W first, then AW) and host clear
    bexp_q.push_back(RESP_OKAY);
    @(negedge ACLK);
    do_w(32'h1);
    check("have_w_state", 64'(dbg_wr_state), 64'(W_HAVE_W));
    check("irq_pre_conflict", 64'(irq), 64'(0));
    AWADDR = 32'h14; AWVALID = 1'b1;
    HOST_WE = 1'b1; HOST_ADDR = OFF_STATUS; HOST_WDATA = 32'h1;
    check("have_w_awready", 64'(AWREADY), 64'(1));
    @(negedge ACLK);
    AWVALID = 1'b0; HOST_WE = 1'b0;
    check("set_wins_irq", 64'(irq), 64'(1));
    collect_b("set_wins");
    check("set_wins_irq_hold", 64'(irq), 64'(1));
    host_write(OFF_STATUS, 32'h1);

    // SLVERR cases
    axi_write(32'h04, 32'hDEAD, 2, 1, RESP_SLVERR, "wr_vec_a");
    axi_write(32'h00, 32'h5, 0, 0, RESP_SLVERR, "wr_control");
    axi_write(32'h18, 32'h7, 0, 0, RESP_SLVERR, "wr_result");
    axi_write(32'h12, 32'h9, 1, 0, RESP_SLVERR, "wr_misalign");
    axi_read(32'h1C, 32'h0, RESP_SLVERR, "rd_1c");
    axi_read(32'h02, 32'h0, RESP_SLVERR, "rd_misalign");
    host_check(OFF_VEC_A, 32'h100, "vec_a_unchanged");
    host_check(OFF_CONTROL, 32'h0, "control_unchanged");
    host_check(OFF_RESULT, 32'h2A, "result_unchanged");
    host_check(OFF_OUTPUT, 32'h300, "out_addr_unchanged");

    // read stall: R held, second AR not accepted
    @(negedge ACLK);
    ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
    wait_sig(0, "stall_ar");
    @(negedge ACLK);
    ARADDR = 32'h04;
    for (int i = 0; i < 5; i++) begin
      check("stall_r", 64'({RVALID, ARREADY, RRESP, RDATA}), 64'({1'b1, 1'b0, RESP_OKAY, 32'h200}));
      @(negedge ACLK);
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge ACLK);
    check("stall_r_release", 64'(RVALID), 64'(0));

    // write stall: B held, no new AW/W accepted
    @(negedge ACLK);
    BREADY = 1'b0;
    AWADDR = 32'h10; WDATA = 32'h55; AWVALID = 1'b1; WVALID = 1'b1;
    wait_sig(3, "stall_aww");
    @(negedge ACLK);
    WVALID = 1'b0; AWADDR = 32'h04;
    for (int i = 0; i < 5; i++) begin
      check("stall_b", 64'({BVALID, AWREADY, WREADY, BRESP}), 64'({3'b100, RESP_OKAY}));
      @(negedge ACLK);
    end
    AWVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    check("stall_b_release", 64'(BVALID), 64'(0));
    host_check(OFF_RESULT, 32'h55, "stall_result");

    // reset in W_HAVE_AW
    @(negedge ACLK);
    do_aw(32'h10);
    check("have_aw_state", 64'(dbg_wr_state), 64'(W_HAVE_AW));
    ARESETN = 1'b0;
    #1;
    check("midreset_outputs", 64'(reset_bundle()), 64'(0));
    check("midreset_rdata", 64'(RDATA), 64'(0));
    host_check(OFF_VEC_A, 32'h0, "midreset_vec_a");
    host_check(OFF_RESULT, 32'h0, "midreset_result");
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("postreset_readies", 64'({ARREADY, AWREADY, WREADY}), 64'(3'b111));
    check("postreset_wstate", 64'(dbg_wr_state), 64'(W_IDLE));
    repeat (2) begin
      @(negedge ACLK);
      check("postreset_no_b", 64'(BVALID), 64'(0));
    end

    // random config values round-trip
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'($urandom_range(1, 4) * 4);
      d = $urandom;
      host_write(a, d);
      axi_read({27'b0, a}, d, RESP_OKAY, "rand_cfg");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
